// File: rtl/interval_timer_pkg.sv
// Shared types and defaults for the interval timer and the central FSM that uses it.
// State encodings and default sizing live here so both sides agree on them.
package interval_timer_pkg;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_PRESCALE  = 1;
    localparam int DEF_PRE_WIDTH = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // True when a prescale count fits a counter of the given width.
    function automatic bit prescale_fits(input int pre, input int w);
        if (pre < 1)
            return 1'b0;
        if (w >= 31)
            return 1'b1;
        return pre <= (1 << w);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running clock divider: one tick every PRESCALE enabled cycles.
// Shared between the interval timer and the tempo generator.
module tick_divider #(
    parameter int PRESCALE  = 1,
    parameter int PRE_WIDTH = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam logic [PRE_WIDTH-1:0] LAST = PRE_WIDTH'(PRESCALE - 1);

    logic [PRE_WIDTH-1:0] pre_q;

    assign tick = enable && (pre_q == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            pre_q <= '0;
        else if (clear)
            pre_q <= '0;
        else if (enable)
            pre_q <= tick ? '0 : pre_q + PRE_WIDTH'(1);
    end

endmodule

// File: rtl/interval_timer.sv
// Counts a runtime target of prescaled ticks and pulses done on expiry.
// Optional auto-reload (periodic) mode is built with INTERVAL_TIMER_RELOAD_EN.
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int PRESCALE  = DEF_PRESCALE,
    parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] target,
`ifdef INTERVAL_TIMER_RELOAD_EN
    input  logic             periodic,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("interval_timer: WIDTH must be 1..32");
        end
        if (!prescale_fits(PRESCALE, PRE_WIDTH)) begin : g_bad_prescale
            $error("interval_timer: PRESCALE must be >= 1 and fit in PRE_WIDTH bits");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] count_inc;
    logic             per_q, per_d;
    logic             done_q, done_d;
    logic             per_in;
    logic             tick;
    logic             div_clear;

`ifdef INTERVAL_TIMER_RELOAD_EN
    assign per_in = periodic;
`else
    assign per_in = 1'b0;
`endif

    tick_divider #(
        .PRESCALE  (PRESCALE),
        .PRE_WIDTH (PRE_WIDTH)
    ) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == ST_RUN),
        .clear  (div_clear),
        .tick   (tick)
    );

    assign count_inc = count_q + WIDTH'(1);

    // Priority: stop, then start (fresh or restart), then tick progress.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        count_d   = count_q;
        per_d     = per_q;
        done_d    = 1'b0;
        div_clear = (state_q == ST_IDLE);

        if (stop) begin
            state_d   = ST_IDLE;
            count_d   = '0;
            div_clear = 1'b1;
        end else if (start) begin
            tgt_d     = target;
            per_d     = per_in && (target != '0);
            count_d   = '0;
            div_clear = 1'b1;
            if (target == '0) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if (state_q == ST_RUN && tick) begin
            if (count_inc == tgt_q) begin
                // Expiry: the divider wraps to 0 on this tick by itself.
                done_d  = 1'b1;
                count_d = '0;
                if (!per_q)
                    state_d = ST_IDLE;
            end else begin
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            tgt_q   <= '0;
            count_q <= '0;
            per_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            count_q <= count_d;
            per_q   <= per_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign count = count_q;

endmodule
